// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Pipelined-latency multiply, restoring radix-2 divide, MTHI/MTLO, flush.
module muldiv_unit #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned MUL_STAGES = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [WIDTH-1:0] req_src1,
    input  logic [WIDTH-1:0] req_src2,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi_rdata,
    output logic [WIDTH-1:0] lo_rdata
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_FIX  = 2'd3;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    logic [1:0]         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_opa;      // multiplicand, or dividend shifting into quotient
    logic [WIDTH-1:0]   r_opb;      // multiplier, or divisor magnitude
    logic [WIDTH-1:0]   r_rem;
    logic               r_signed;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_dz;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;

    logic [1:0]         w_state_nx;
    logic [CNT_W-1:0]   w_cnt_nx;
    logic [WIDTH-1:0]   w_opa_nx;
    logic [WIDTH-1:0]   w_opb_nx;
    logic [WIDTH-1:0]   w_rem_nx;
    logic               w_signed_nx;
    logic               w_neg_q_nx;
    logic               w_neg_r_nx;
    logic               w_dz_nx;
    logic [WIDTH-1:0]   w_hi_nx;
    logic [WIDTH-1:0]   w_lo_nx;
    logic               w_done_nx;

    logic               w_accept;
    logic               w_neg1;
    logic               w_neg2;
    logic [WIDTH-1:0]   w_abs1;
    logic [WIDTH-1:0]   w_abs2;
    logic [2*WIDTH-1:0] w_mul_a;
    logic [2*WIDTH-1:0] w_mul_b;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH:0]     w_diff;
    logic               w_ge;
    logic [WIDTH-1:0]   w_quo_f;
    logic [WIDTH-1:0]   w_rem_f;

    assign req_ready = (r_state == S_IDLE) && !cancel;
    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;
    assign hi_rdata  = r_hi;
    assign lo_rdata  = r_lo;
    assign w_accept  = req_valid && req_ready;

    // Operand magnitudes for signed divide; two's-complement min maps onto itself as unsigned 2^(W-1)
    assign w_neg1 = (req_op == OP_DIV) && req_src1[WIDTH-1];
    assign w_neg2 = (req_op == OP_DIV) && req_src2[WIDTH-1];
    assign w_abs1 = w_neg1 ? (~req_src1 + WIDTH'(1)) : req_src1;
    assign w_abs2 = w_neg2 ? (~req_src2 + WIDTH'(1)) : req_src2;

    // Full-width product of the latched operands, sign- or zero-extended
    assign w_mul_a = r_signed ? {{WIDTH{r_opa[WIDTH-1]}}, r_opa} : {{WIDTH{1'b0}}, r_opa};
    assign w_mul_b = r_signed ? {{WIDTH{r_opb[WIDTH-1]}}, r_opb} : {{WIDTH{1'b0}}, r_opb};
    assign w_prod  = w_mul_a * w_mul_b;

    // One restoring-division step: shift in the next dividend bit and trial-subtract
    assign w_rem_sh = {r_rem, r_opa[WIDTH-1]};
    assign w_diff   = w_rem_sh - {1'b0, r_opb};
    assign w_ge     = !w_diff[WIDTH];

    // Sign fixup applied in the final cycle
    assign w_quo_f = r_neg_q ? (~r_opa + WIDTH'(1)) : r_opa;
    assign w_rem_f = r_neg_r ? (~r_rem + WIDTH'(1)) : r_rem;

    // State register and all datapath registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_opa    <= '0;
            r_opb    <= '0;
            r_rem    <= '0;
            r_signed <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_dz     <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_cnt    <= w_cnt_nx;
            r_opa    <= w_opa_nx;
            r_opb    <= w_opb_nx;
            r_rem    <= w_rem_nx;
            r_signed <= w_signed_nx;
            r_neg_q  <= w_neg_q_nx;
            r_neg_r  <= w_neg_r_nx;
            r_dz     <= w_dz_nx;
            r_hi     <= w_hi_nx;
            r_lo     <= w_lo_nx;
            r_done   <= w_done_nx;
        end
    end

    // Next-state and next-register logic; cancel overrides any in-flight result
    always_comb begin
        w_state_nx  = r_state;
        w_cnt_nx    = r_cnt;
        w_opa_nx    = r_opa;
        w_opb_nx    = r_opb;
        w_rem_nx    = r_rem;
        w_signed_nx = r_signed;
        w_neg_q_nx  = r_neg_q;
        w_neg_r_nx  = r_neg_r;
        w_dz_nx     = r_dz;
        w_hi_nx     = r_hi;
        w_lo_nx     = r_lo;
        w_done_nx   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    case (req_op)
                        OP_MULT, OP_MULTU: begin
                            w_state_nx  = S_MUL;
                            w_cnt_nx    = CNT_W'(MUL_STAGES - 1);
                            w_opa_nx    = req_src1;
                            w_opb_nx    = req_src2;
                            w_signed_nx = (req_op == OP_MULT);
                        end
                        OP_DIV, OP_DIVU: begin
                            w_state_nx = S_DIV;
                            w_cnt_nx   = CNT_W'(WIDTH);
                            w_opa_nx   = w_abs1;
                            w_opb_nx   = w_abs2;
                            w_rem_nx   = '0;
                            w_neg_q_nx = w_neg1 ^ w_neg2;
                            w_neg_r_nx = w_neg1;
                            w_dz_nx    = (req_src2 == '0);
                        end
                        OP_MTHI: begin
                            w_hi_nx   = req_src1;
                            w_done_nx = 1'b1;
                        end
                        OP_MTLO: begin
                            w_lo_nx   = req_src1;
                            w_done_nx = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            S_MUL: begin
                if (r_cnt == '0) begin
                    w_hi_nx    = w_prod[2*WIDTH-1:WIDTH];
                    w_lo_nx    = w_prod[WIDTH-1:0];
                    w_done_nx  = 1'b1;
                    w_state_nx = S_IDLE;
                end else begin
                    w_cnt_nx = r_cnt - CNT_W'(1);
                end
            end
            S_DIV: begin
                w_rem_nx = w_ge ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
                w_opa_nx = {r_opa[WIDTH-2:0], w_ge};
                w_cnt_nx = r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nx = S_FIX;
                end
            end
            S_FIX: begin
                // Divide by zero keeps the full latency and pulses done, but leaves HI/LO intact
                if (!r_dz) begin
                    w_lo_nx = w_quo_f;
                    w_hi_nx = w_rem_f;
                end
                w_done_nx  = 1'b1;
                w_state_nx = S_IDLE;
            end
        endcase

        if (cancel && (r_state != S_IDLE)) begin
            w_state_nx = S_IDLE;
            w_hi_nx    = r_hi;
            w_lo_nx    = r_lo;
            w_done_nx  = 1'b0;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed table, random ops vs arithmetic model, corner sequences.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_src1;
    logic [31:0] req_src2;
    logic        cancel;
    logic        busy;
    logic        done;
    logic [31:0] hi_rdata;
    logic [31:0] lo_rdata;

    logic        s_valid;
    logic        s_ready;
    logic [2:0]  s_op;
    logic [15:0] s_src1;
    logic [15:0] s_src2;
    logic        s_cancel;
    logic        s_busy;
    logic        s_done;
    logic [15:0] s_hi;
    logic [15:0] s_lo;

    int n_pass = 0;
    int n_tot  = 0;

    logic [31:0] m_hi;
    logic [31:0] m_lo;

    muldiv_unit #(.WIDTH(32), .MUL_STAGES(2)) u_dut (
        .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_src1(req_src1), .req_src2(req_src2), .cancel(cancel),
        .busy(busy), .done(done), .hi_rdata(hi_rdata), .lo_rdata(lo_rdata)
    );

    muldiv_unit #(.WIDTH(16), .MUL_STAGES(4)) u_dut16 (
        .clk(clk), .resetn(resetn), .req_valid(s_valid), .req_ready(s_ready),
        .req_op(s_op), .req_src1(s_src1), .req_src2(s_src2), .cancel(s_cancel),
        .busy(s_busy), .done(s_done), .hi_rdata(s_hi), .lo_rdata(s_lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
        int          bsy;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Done-wait from the cycle after the accept edge; lat = edges after accept before done is seen
    task automatic wait_done(input int limit, input logic [31:0] oh, input logic [31:0] ol,
                             output int lat, output int bsy, output bit early);
        lat = -1; bsy = 0; early = 1'b0;
        for (int k = 0; k < limit; k++) begin
            @(negedge clk);
            if (busy) bsy++;
            if (done) begin
                lat = k;
                break;
            end
            if (hi_rdata !== oh || lo_rdata !== ol) early = 1'b1;
            @(posedge clk); #1;
        end
    endtask

    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int bsy, output bit early);
        logic [31:0] oh;
        logic [31:0] ol;
        oh = m_hi; ol = m_lo;
        req_op = op; req_src1 = a; req_src2 = b; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_src1 = $urandom; req_src2 = $urandom; req_op = 3'($urandom);
        wait_done(40, oh, ol, lat, bsy, early);
    endtask

    // Architectural reference: HI/LO effect plus expected latency and busy-cycle count
    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int bsy);
        longint      sa, sb;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        lat = -1; bsy = 0;
        case (op)
            3'd0: begin p = 64'(sa * sb); m_hi = p[63:32]; m_lo = p[31:0]; lat = 2; bsy = 2; end
            3'd1: begin p = {32'b0, a} * {32'b0, b}; m_hi = p[63:32]; m_lo = p[31:0]; lat = 2; bsy = 2; end
            3'd2: begin
                if (b != 0) begin m_lo = 32'(sa / sb); m_hi = 32'(sa % sb); end
                lat = 33; bsy = 33;
            end
            3'd3: begin
                if (b != 0) begin m_lo = a / b; m_hi = a % b; end
                lat = 33; bsy = 33;
            end
            3'd4: begin m_hi = a; lat = 0; end
            3'd5: begin m_lo = a; lat = 0; end
            default: ;
        endcase
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    task automatic op16(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] eh, input logic [15:0] el, input int elat, input string nm);
        int lat;
        lat = -1;
        s_op = op; s_src1 = a; s_src2 = b; s_valid = 1'b1;
        @(posedge clk); #1;
        s_valid = 1'b0; s_src1 = 16'($urandom); s_src2 = 16'($urandom);
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (s_done) begin lat = k; break; end
            @(posedge clk); #1;
        end
        chk({nm, "_lat"}, 64'(lat), 64'(elat));
        chk({nm, "_hi"}, 64'(s_hi), 64'(eh));
        chk({nm, "_lo"}, 64'(s_lo), 64'(el));
    endtask

    initial begin
        vec_t tbl[10];
        int   lat, bsy, elat, ebsy;
        bit   early, seen;
        logic [2:0]  op;
        logic [31:0] a, b;

        tbl[0] = '{3'd0, 32'hFFFF_FFFD, 32'h5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 2, 2};
        tbl[1] = '{3'd1, 32'hFFFF_FFFD, 32'h5,         32'h0000_0004, 32'hFFFF_FFF1, 2, 2};
        tbl[2] = '{3'd2, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, 33};
        tbl[3] = '{3'd3, 32'hFFFF_FFFF, 32'h10,        32'h0000_000F, 32'h0FFF_FFFF, 33, 33};
        tbl[4] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 33, 33};
        tbl[5] = '{3'd4, 32'h0000_1234, 32'h0,         32'h0000_1234, 32'h8000_0000, 0, 0};
        tbl[6] = '{3'd5, 32'h0000_CAFE, 32'h0,         32'h0000_1234, 32'h0000_CAFE, 0, 0};
        tbl[7] = '{3'd3, 32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E, 33, 33};
        tbl[8] = '{3'd0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 2, 2};
        tbl[9] = '{3'd6, 32'h1111_1111, 32'h2222_2222, 32'h3FFF_FFFF, 32'h0000_0001, -1, 0};

        resetn = 1'b0; req_valid = 1'b0; req_op = 3'd0; req_src1 = '0; req_src2 = '0; cancel = 1'b0;
        s_valid = 1'b0; s_op = 3'd0; s_src1 = '0; s_src2 = '0; s_cancel = 1'b0;
        m_hi = '0; m_lo = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 64'(req_ready), 64'(1));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_hi", 64'(hi_rdata), 64'(0));
        chk("rst_lo", 64'(lo_rdata), 64'(0));
        @(posedge clk); #1;
        resetn = 1'b1;

        // Directed vectors
        for (int i = 0; i < 10; i++) begin
            do_op(tbl[i].op, tbl[i].a, tbl[i].b, lat, bsy, early);
            chk($sformatf("vec%0d_hi", i), 64'(hi_rdata), 64'(tbl[i].hi));
            chk($sformatf("vec%0d_lo", i), 64'(lo_rdata), 64'(tbl[i].lo));
            chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(tbl[i].lat));
            chk($sformatf("vec%0d_busy", i), 64'(bsy), 64'(tbl[i].bsy));
            chk($sformatf("vec%0d_early", i), 64'(early), 64'(0));
            m_hi = tbl[i].hi; m_lo = tbl[i].lo;
        end

        // Random ops against the model
        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom_range(0, 7));
            a = pick(); b = pick();
            do_op(op, a, b, lat, bsy, early);
            model(op, a, b, elat, ebsy);
            chk($sformatf("rnd%0d_op%0d_hi", i, op), 64'(hi_rdata), 64'(m_hi));
            chk($sformatf("rnd%0d_op%0d_lo", i, op), 64'(lo_rdata), 64'(m_lo));
            chk($sformatf("rnd%0d_op%0d_lat", i, op), 64'(lat), 64'(elat));
            chk($sformatf("rnd%0d_op%0d_busy", i, op), 64'(bsy), 64'(ebsy));
            chk($sformatf("rnd%0d_op%0d_early", i, op), 64'(early), 64'(0));
        end

        // MTHI then divide-by-zero back-to-back
        req_op = 3'd4; req_src1 = 32'h1234; req_valid = 1'b1;
        @(posedge clk); #1;
        req_op = 3'd2; req_src1 = 32'd5; req_src2 = 32'd0;
        @(negedge clk);
        chk("b2b_mthi_done", 64'(done), 64'(1));
        chk("b2b_mthi_hi", 64'(hi_rdata), 64'h1234);
        chk("b2b_ready", 64'(req_ready), 64'(1));
        m_hi = 32'h1234;
        @(posedge clk); #1;
        req_valid = 1'b0;
        wait_done(40, m_hi, m_lo, lat, bsy, early);
        chk("dz_lat", 64'(lat), 64'(33));
        chk("dz_busy_cycles", 64'(bsy), 64'(33));
        chk("dz_hi", 64'(hi_rdata), 64'h1234);
        chk("dz_lo", 64'(lo_rdata), 64'(m_lo));
        chk("dz_early", 64'(early), 64'(0));
        chk("dz_busy_drop", 64'(busy), 64'(0));

        // Cancel mid-divide
        req_op = 3'd3; req_src1 = 32'd100; req_src2 = 32'd7; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1 cancel = 1'b1;
        @(negedge clk);
        chk("cxl_busy_before", 64'(busy), 64'(1));
        @(posedge clk); #1;
        cancel = 1'b0;
        @(negedge clk);
        chk("cxl_idle", 64'(busy), 64'(0));
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk("cxl_no_done", 64'(seen), 64'(0));
        chk("cxl_hi", 64'(hi_rdata), 64'(m_hi));
        chk("cxl_lo", 64'(lo_rdata), 64'(m_lo));

        // Cancel concurrent with a request in IDLE blocks the accept
        @(posedge clk); #1;
        cancel = 1'b1; req_valid = 1'b1; req_op = 3'd5; req_src1 = 32'hDEAD;
        @(negedge clk);
        chk("cxl_idle_ready", 64'(req_ready), 64'(0));
        @(posedge clk); #1;
        cancel = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        chk("cxl_idle_done", 64'(done), 64'(0));
        chk("cxl_idle_lo", 64'(lo_rdata), 64'(m_lo));

        // Reset mid-divide
        @(posedge clk); #1;
        req_op = 3'd2; req_src1 = 32'd1000; req_src2 = 32'd3; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 resetn = 1'b0;
        #1;
        chk("mrst_busy", 64'(busy), 64'(0));
        chk("mrst_hi", 64'(hi_rdata), 64'(0));
        chk("mrst_lo", 64'(lo_rdata), 64'(0));
        m_hi = '0; m_lo = '0;
        @(posedge clk); #1;
        resetn = 1'b1;
        do_op(3'd1, 32'd6, 32'd7, lat, bsy, early);
        chk("post_rst_lat", 64'(lat), 64'(2));
        chk("post_rst_hi", 64'(hi_rdata), 64'(0));
        chk("post_rst_lo", 64'(lo_rdata), 64'(42));

        // 16-bit, 4-stage multiply instance
        @(posedge clk); #1;
        op16(3'd0, 16'h8000, 16'h8000, 16'h4000, 16'h0000, 4, "w16_mult");
        op16(3'd2, 16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 17, "w16_div");
        op16(3'd1, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001, 4, "w16_multu");
        op16(3'd3, 16'hFFFF, 16'h0003, 16'h0000, 16'h5555, 17, "w16_divu");

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
